// File: rtl/wb_regfile.sv
// Architectural integer register file with same-cycle writeback bypass and a
// pending-write scoreboard that stalls issue on RAW/WAW hazards.
module wb_regfile #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  localparam int AW      = $clog2(NUM_REGS),
  localparam int CW      = AW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_rd_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_ready,
  output logic            rs2_ready,
  input  logic            issue_valid,
  input  logic            issue_uses_rd,
  input  logic [AW-1:0]   issue_rd_addr,
  output logic            issue_ready,
  input  logic            flush,
  output logic [CW-1:0]   pending_cnt
);

  logic [XLEN-1:0]     regs_q [NUM_REGS];
  logic [XLEN-1:0]     regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;
  logic [CW-1:0]       cnt_q;
  logic [CW-1:0]       cnt_d;

  logic wb_hit1, wb_hit2, wb_hit_rd;
  logic waw, fire;

  function automatic logic [CW-1:0] popcount(input logic [NUM_REGS-1:0] bits);
    logic [CW-1:0] acc;
    acc = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      acc = acc + CW'(bits[i]);
    end
    return acc;
  endfunction

  // A writeback arriving this cycle both supplies the operand and resolves its hazard.
  always_comb begin
    wb_hit1   = wb_en && (wb_rd_addr == rs1_addr);
    wb_hit2   = wb_en && (wb_rd_addr == rs2_addr);
    wb_hit_rd = wb_en && (wb_rd_addr == issue_rd_addr);

    if (rs1_addr == '0)   rs1_data = '0;
    else if (wb_hit1)     rs1_data = wb_data;
    else                  rs1_data = regs_q[rs1_addr];

    if (rs2_addr == '0)   rs2_data = '0;
    else if (wb_hit2)     rs2_data = wb_data;
    else                  rs2_data = regs_q[rs2_addr];

    rs1_ready = (rs1_addr == '0) || !pending_q[rs1_addr] || wb_hit1;
    rs2_ready = (rs2_addr == '0) || !pending_q[rs2_addr] || wb_hit2;

    waw  = issue_uses_rd && (issue_rd_addr != '0) && pending_q[issue_rd_addr] && !wb_hit_rd;
    fire = issue_valid && rs1_ready && rs2_ready && !waw && !flush;
    issue_ready = fire;
  end

  always_comb begin
    regs_d = regs_q;
    if (wb_en && (wb_rd_addr != '0)) begin
      regs_d[wb_rd_addr] = wb_data;
    end
  end

  // Clear before set so a new producer keeps ownership of a register retiring this cycle.
  always_comb begin
    pending_d = pending_q;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (wb_en && (wb_rd_addr == AW'(i))) pending_d[i] = 1'b0;
      if (fire && issue_uses_rd && (issue_rd_addr == AW'(i))) pending_d[i] = 1'b1;
    end
    if (flush) pending_d = '0;
    pending_d[0] = 1'b0;
    cnt_d = popcount(pending_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q    <= '{default: '0};
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      regs_q    <= regs_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pending_cnt = cnt_q;

endmodule
